// File: rtl/vc_traffic_source.sv
// Per-VC packet source for arbiter/switch benches: LFSR-driven request, destination and length generation.
// Optional VC_SRC_STATS_EN adds saturating per-VC packet and total flit counters.
module vc_traffic_source #(
    parameter int          VC_NUM     = 3,
    parameter int          PRIO_NUM   = 2,
    parameter int          OUTPUT_NUM = 8,
    parameter int          MAX_PKTS   = 4,
    parameter int          MAX_FLITS  = 8,
    parameter logic [15:0] SEED       = 16'hACE1,
    localparam int         N          = VC_NUM * PRIO_NUM,
    localparam int         VCW        = (N > 1) ? $clog2(N) : 1,
    localparam int         PCW        = $clog2(MAX_PKTS + 1),
    localparam int         FCW        = $clog2(MAX_FLITS + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    fixed_mode,
    input  logic [N-1:0]            fixed_vcs,
    input  logic [PCW-1:0]          pkts_per_vc,
    input  logic [VCW-1:0]          selected_vc,
    input  logic                    cts,
    output logic [N-1:0]            o_has_packet,
    output logic [N*OUTPUT_NUM-1:0] o_dest,
    output logic [N*VCW-1:0]        o_output_vc,
    output logic                    o_valid,
    output logic                    o_last,
    output logic [VCW-1:0]          o_flit_vc,
    output logic                    o_busy
`ifdef VC_SRC_STATS_EN
    ,
    output logic [N*16-1:0]         o_pkt_sent,
    output logic [31:0]             o_flit_sent
`endif
);

    // state  | meaning
    // IDLE   | no request, waiting for enable and a start bit
    // LOAD   | latch burst size, clear packet count, pick destination
    // REQ    | requesting the arbiter, waiting for a grant
    // XFER   | owns the flit channel, one flit per cts cycle
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_XFER} state_e;

    localparam logic [31:0]           MAXP_U   = 32'(MAX_PKTS);
    localparam logic [31:0]           MAXF_U   = 32'(MAX_FLITS);
    localparam logic [31:0]           OUTM1_U  = 32'(OUTPUT_NUM - 1);
    localparam logic [OUTPUT_NUM-1:0] DEST_LSB = OUTPUT_NUM'(1);
    localparam int                    SELW     = 1 << VCW;

    state_e                state_q    [N];
    state_e                state_d    [N];
    logic [PCW-1:0]        target_q   [N];
    logic [PCW-1:0]        target_d   [N];
    logic [PCW-1:0]        pkt_cnt_q  [N];
    logic [PCW-1:0]        pkt_cnt_d  [N];
    logic [OUTPUT_NUM-1:0] dest_q     [N];
    logic [OUTPUT_NUM-1:0] dest_d     [N];
    logic [VCW-1:0]        owner_q, owner_d;
    logic [FCW-1:0]        flen_q, flen_d;
    logic [FCW-1:0]        flit_cnt_q, flit_cnt_d;
    logic [15:0]           lfsr_q, lfsr_d;

    logic [N-1:0]          req_vec, xfer_vec;
    logic [SELW-1:0]       req_ext;
    logic                  busy, grant_any, flit_last;
    logic [PCW-1:0]        rand_pkts;
    logic [FCW-1:0]        new_flen;
    logic [OUTPUT_NUM-1:0] new_dest;

    assign lfsr_d = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};

    assign rand_pkts = PCW'(32'd1 + (32'(lfsr_q) % MAXP_U));
    assign new_flen  = FCW'(32'd1 + (32'(lfsr_q[15:8]) % MAXF_U));
    assign new_dest  = DEST_LSB << (32'd1 + (32'(lfsr_q[15:4]) % OUTM1_U));

    always_comb begin
        req_vec  = '0;
        xfer_vec = '0;
        for (int i = 0; i < N; i++) begin
            req_vec[i]  = (state_q[i] == S_REQ);
            xfer_vec[i] = (state_q[i] == S_XFER);
        end
    end

    // Padding to a power of two makes out-of-range selected_vc read a zero request.
    assign req_ext   = SELW'(req_vec);
    assign busy      = |xfer_vec;
    assign grant_any = cts & ~busy & req_ext[selected_vc];
    assign flit_last = busy & cts & ((flit_cnt_q + 1'b1) == flen_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) state_q[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: if (enable && (fixed_mode ? fixed_vcs[i] : lfsr_q[i % 16]))
                            state_d[i] = S_LOAD;
                S_LOAD: state_d[i] = S_REQ;
                S_REQ:  if (grant_any && (selected_vc == VCW'(i)))
                            state_d[i] = S_XFER;
                S_XFER: if (flit_last)
                            state_d[i] = ((pkt_cnt_q[i] + 1'b1) == target_q[i]) ? S_IDLE : S_REQ;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        owner_d    = owner_q;
        flen_d     = flen_q;
        flit_cnt_d = flit_cnt_q;
        for (int i = 0; i < N; i++) begin
            target_d[i]  = target_q[i];
            pkt_cnt_d[i] = pkt_cnt_q[i];
            dest_d[i]    = dest_q[i];
            if (state_q[i] == S_LOAD) begin
                target_d[i]  = fixed_mode ? PCW'(1) : ((pkts_per_vc != '0) ? pkts_per_vc : rand_pkts);
                pkt_cnt_d[i] = '0;
                dest_d[i]    = new_dest;
            end else if ((state_q[i] == S_XFER) && flit_last) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + 1'b1;
                dest_d[i]    = ((pkt_cnt_q[i] + 1'b1) == target_q[i]) ? '0 : new_dest;
            end
        end
        if (grant_any) begin
            owner_d    = selected_vc;
            flen_d     = new_flen;
            flit_cnt_d = '0;
        end else if (busy && cts) begin
            flit_cnt_d = flit_last ? '0 : flit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q     <= SEED;
            owner_q    <= '0;
            flen_q     <= '0;
            flit_cnt_q <= '0;
            for (int i = 0; i < N; i++) begin
                target_q[i]  <= '0;
                pkt_cnt_q[i] <= '0;
                dest_q[i]    <= '0;
            end
        end else begin
            lfsr_q     <= lfsr_d;
            owner_q    <= owner_d;
            flen_q     <= flen_d;
            flit_cnt_q <= flit_cnt_d;
            for (int i = 0; i < N; i++) begin
                target_q[i]  <= target_d[i];
                pkt_cnt_q[i] <= pkt_cnt_d[i];
                dest_q[i]    <= dest_d[i];
            end
        end
    end

    always_comb begin
        o_has_packet = '0;
        o_dest       = '0;
        o_output_vc  = '0;
        for (int i = 0; i < N; i++) begin
            o_has_packet[i] = (state_q[i] == S_REQ) || (state_q[i] == S_XFER);
            if (state_q[i] != S_IDLE) begin
                o_dest[i*OUTPUT_NUM +: OUTPUT_NUM] = dest_q[i];
                o_output_vc[i*VCW +: VCW]          = VCW'(i);
            end
        end
        o_valid   = busy & cts;
        o_last    = flit_last;
        o_flit_vc = busy ? owner_q : '0;
        o_busy    = busy;
    end

`ifdef VC_SRC_STATS_EN
    logic [15:0] pkt_sent_q [N];
    logic [31:0] flit_sent_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            flit_sent_q <= '0;
            for (int i = 0; i < N; i++) pkt_sent_q[i] <= '0;
        end else begin
            if (o_valid && (flit_sent_q != '1)) flit_sent_q <= flit_sent_q + 1'b1;
            for (int i = 0; i < N; i++) begin
                if (flit_last && (owner_q == VCW'(i)) && (pkt_sent_q[i] != '1))
                    pkt_sent_q[i] <= pkt_sent_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        o_pkt_sent = '0;
        for (int i = 0; i < N; i++) o_pkt_sent[i*16 +: 16] = pkt_sent_q[i];
        o_flit_sent = flit_sent_q;
    end
`endif

endmodule

// File: tb/tb_vc_traffic_source.sv
// Directed bench for vc_traffic_source: default instance plus a MAX_FLITS=1 instance sharing inputs.
// LFSR-derived lengths and destinations come from an independent model of the polynomial.
module tb_vc_traffic_source;
    localparam int N    = 6;
    localparam int ONUM = 8;
    localparam int VCW  = 3;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           enable = 1'b0;
    logic           fixed_mode = 1'b0;
    logic           cts = 1'b0;
    logic [N-1:0]   fixed_vcs = '0;
    logic [2:0]     pkts_per_vc = '0;
    logic [VCW-1:0] selected_vc = 3'd7;

    logic [N-1:0]      has0, has1;
    logic [N*ONUM-1:0] dest0, dest1;
    logic [N*VCW-1:0]  ovc0, ovc1;
    logic              valid0, valid1, last0, last1, busy0, busy1;
    logic [VCW-1:0]    fvc0, fvc1;
`ifdef VC_SRC_STATS_EN
    logic [N*16-1:0]   pkt0, pkt1;
    logic [31:0]       fl0, fl1;
`endif

    logic              use1 = 1'b0;
    logic              t_valid, t_last, t_busy;
    logic [VCW-1:0]    t_fvc;
    logic [15:0]       m_lfsr;
    int                n_chk = 0;
    int                n_pass = 0;

    always #5 clk = ~clk;

    vc_traffic_source u_dut (
        .clk(clk), .resetn(resetn), .enable(enable), .fixed_mode(fixed_mode),
        .fixed_vcs(fixed_vcs), .pkts_per_vc(pkts_per_vc), .selected_vc(selected_vc), .cts(cts),
        .o_has_packet(has0), .o_dest(dest0), .o_output_vc(ovc0), .o_valid(valid0),
        .o_last(last0), .o_flit_vc(fvc0), .o_busy(busy0)
`ifdef VC_SRC_STATS_EN
        , .o_pkt_sent(pkt0), .o_flit_sent(fl0)
`endif
    );

    vc_traffic_source #(.MAX_FLITS(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .enable(enable), .fixed_mode(fixed_mode),
        .fixed_vcs(fixed_vcs), .pkts_per_vc(pkts_per_vc), .selected_vc(selected_vc), .cts(cts),
        .o_has_packet(has1), .o_dest(dest1), .o_output_vc(ovc1), .o_valid(valid1),
        .o_last(last1), .o_flit_vc(fvc1), .o_busy(busy1)
`ifdef VC_SRC_STATS_EN
        , .o_pkt_sent(pkt1), .o_flit_sent(fl1)
`endif
    );

    assign t_valid = use1 ? valid1 : valid0;
    assign t_last  = use1 ? last1  : last0;
    assign t_busy  = use1 ? busy1  : busy0;
    assign t_fvc   = use1 ? fvc1   : fvc0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic [7:0] dest_of(input logic [15:0] x);
        logic [7:0] one;
        int k;
        one = 8'd1;
        k = 1 + (int'(x >> 4) % 7);
        return one << k;
    endfunction

    function automatic int flen_of(input logic [15:0] x);
        return 1 + (int'(x[15:8]) % (use1 ? 1 : 8));
    endfunction

    always @(posedge clk) begin
        if (!resetn) m_lfsr <= 16'hACE1;
        else         m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Holds cts low until the modelled LFSR promises a packet of at least min_len flits, then grants.
    task automatic grant_wait(input int vc, input int min_len, output int len);
        int g;
        selected_vc = VCW'(vc);
        cts = 1'b1;
        len = flen_of(m_lfsr);
        g = 0;
        while (len < min_len && g < 40) begin
            cts = 1'b0;
            tick;
            cts = 1'b1;
            len = flen_of(m_lfsr);
            g++;
        end
        check_val("len_search", 64'(len >= min_len), 64'd1);
        tick;
    endtask

    task automatic xfer_packet(input int vc, input int min_len, input int stall_after,
                               input int stall_len, input int intr);
        int len, n, st, g, obs_flits, obs_last;
        grant_wait(vc, min_len, len);
        n = 0; st = 0; g = 0; obs_flits = 0; obs_last = 0;
        while (n < len && g < len + stall_len + 4) begin
            obs_flits += int'(t_valid);
            obs_last  += int'(t_valid & t_last);
            if (cts) begin
                check_val("flit_valid", 64'(t_valid), 64'd1);
                check_val("flit_vc", 64'(t_fvc), 64'(vc));
                check_val("flit_last", 64'(t_last), 64'(n + 1 == len));
                n++;
            end else begin
                check_val("stall_valid", 64'(t_valid), 64'd0);
                check_val("stall_busy", 64'(t_busy), 64'd1);
            end
            if (n < len) begin
                if (n == stall_after && st < stall_len) begin
                    cts = 1'b0;
                    st++;
                end else begin
                    cts = 1'b1;
                end
                if (intr >= 0 && n >= 1) selected_vc = (n % 2 == 1) ? VCW'(intr) : 3'd7;
                tick;
            end
            g++;
        end
        check_val("flit_total", 64'(obs_flits), 64'(len));
        check_val("last_count", 64'(obs_last), 64'd1);
        selected_vc = 3'd7;
    endtask

    initial begin
        logic [7:0] exp_dest;
        int len, g;

        // Reset with enable low
        repeat (5) tick;
        check_val("rst_has", 64'(has0), 64'd0);
        check_val("rst_valid", 64'(valid0), 64'd0);
        check_val("rst_dest", 64'(dest0), 64'd0);
        resetn = 1'b1;
        repeat (3) tick;
        check_val("idle_has", 64'(has0), 64'd0);
        check_val("idle_valid", 64'(valid0), 64'd0);
        check_val("idle_dest", 64'(dest0), 64'd0);
        check_val("idle_busy", 64'(busy0), 64'd0);

        // Fixed-mode single packet on VC2; pkts_per_vc is ignored in fixed mode
        fixed_mode = 1'b1; fixed_vcs = 6'b000100; pkts_per_vc = 3'd3;
        enable = 1'b1;
        tick;
        exp_dest = dest_of(m_lfsr);
        enable = 1'b0;
        tick;
        check_val("fx_has", 64'(has0), 64'h04);
        check_val("fx_dest", 64'(dest0[2*ONUM +: ONUM]), 64'(exp_dest));
        check_val("fx_ovc", 64'(ovc0[2*VCW +: VCW]), 64'd2);
        check_val("fx_busy_req", 64'(busy0), 64'd0);
        xfer_packet(2, 1, -1, 0, -1);
        tick;
        check_val("fx_has_after", 64'(has0), 64'd0);
        check_val("fx_busy_after", 64'(busy0), 64'd0);
        check_val("fx_valid_after", 64'(valid0), 64'd0);
        check_val("fx_dest_after", 64'(dest0), 64'd0);

        // cts stall for 3 cycles after the first flit
        enable = 1'b1;
        tick;
        enable = 1'b0;
        tick;
        check_val("st_has", 64'(has0), 64'h04);
        xfer_packet(2, 3, 1, 3, -1);
        tick;
        check_val("st_has_after", 64'(has0), 64'd0);

        // Grants to VC3 and to out-of-range VC7 while VC1 transfers
        fixed_vcs = 6'b001010;
        enable = 1'b1;
        tick;
        enable = 1'b0;
        tick;
        check_val("ig_has", 64'(has0), 64'h0A);
        xfer_packet(1, 3, -1, 0, 3);
        tick;
        check_val("ig_has_after", 64'(has0), 64'h08);
        check_val("ig_busy_after", 64'(busy0), 64'd0);
        xfer_packet(3, 1, -1, 0, -1);
        tick;
        check_val("ig_has_done", 64'(has0), 64'd0);

        // Reset asserted in the middle of a packet
        fixed_vcs = 6'b000001;
        enable = 1'b1;
        tick;
        enable = 1'b0;
        tick;
        grant_wait(0, 3, len);
        check_val("mr_flit1", 64'(valid0), 64'd1);
        tick;
        check_val("mr_flit2_last", 64'(last0), 64'd0);
        resetn = 1'b0;
        tick;
        check_val("mr_has", 64'(has0), 64'd0);
        check_val("mr_valid", 64'(valid0), 64'd0);
        check_val("mr_last", 64'(last0), 64'd0);
        check_val("mr_busy", 64'(busy0), 64'd0);
        check_val("mr_dest", 64'(dest0), 64'd0);
        check_val("mr_fvc", 64'(fvc0), 64'd0);
        check_val("mr_ovc", 64'(ovc0), 64'd0);
`ifdef VC_SRC_STATS_EN
        check_val("mr_pkt_sent", 64'(pkt0[63:0]), 64'd0);
        check_val("mr_flit_sent", 64'(fl0), 64'd0);
`endif
        tick;
        resetn = 1'b1;
        cts = 1'b0;
        selected_vc = 3'd7;

        // MAX_FLITS=1 instance, random start, two packets per burst on VC0
        use1 = 1'b1;
        fixed_mode = 1'b0; pkts_per_vc = 3'd2;
        enable = 1'b1;
        g = 0;
        while (!has1[0] && g < 60) begin
            tick;
            g++;
        end
        enable = 1'b0;
        check_val("b_req", 64'(has1[0]), 64'd1);
        check_val("b_dest_bit0", 64'(dest1[0]), 64'd0);
        check_val("b_dest_onehot", 64'($countones(dest1[0 +: ONUM])), 64'd1);
        xfer_packet(0, 1, -1, 0, -1);
        exp_dest = dest_of(m_lfsr);
        tick;
        check_val("b_rereq", 64'(has1[0]), 64'd1);
        check_val("b_new_dest", 64'(dest1[0 +: ONUM]), 64'(exp_dest));
        check_val("b_busy_gap", 64'(busy1), 64'd0);
        xfer_packet(0, 1, -1, 0, -1);
        tick;
        check_val("b_idle", 64'(has1[0]), 64'd0);
        check_val("b_dest_idle", 64'(dest1[0 +: ONUM]), 64'd0);
`ifdef VC_SRC_STATS_EN
        check_val("b_pkt_sent", 64'(pkt1[15:0]), 64'd2);
        check_val("b_flit_sent", 64'(fl1), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
